// File: rtl/cordic_quadrant_ctrl.sv
// Full-circle wrapper around the non-pipelined CORDIC core: reduces a quadrant-tagged
// angle to the first quadrant, runs the core, then restores sign and swap.
module cordic_quadrant_ctrl #(
    parameter int unsigned              BIT_WIDTH = 16,
    parameter logic [BIT_WIDTH-1:0]     K         = 16'd39797
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic [BIT_WIDTH+1:0]        i_req_angle,
    output logic                        o_res_valid,
    input  logic                        i_res_ready,
    output logic signed [BIT_WIDTH:0]   o_res_cos,
    output logic signed [BIT_WIDTH:0]   o_res_sin,
    output logic                        o_core_start,
    output logic                        o_core_mode,
    output logic [BIT_WIDTH-1:0]        o_core_angle,
    output logic [BIT_WIDTH-1:0]        o_core_x,
    output logic [BIT_WIDTH-1:0]        o_core_y,
    input  logic                        i_core_ready,
    input  logic                        i_core_done,
    input  logic [BIT_WIDTH-1:0]        i_core_out_x,
    input  logic [BIT_WIDTH-1:0]        i_core_out_y
);

    typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StHold} state_e;

    state_e                 r_state;
    logic [1:0]             r_quad;
    logic [BIT_WIDTH-1:0]   r_angle;
    logic [BIT_WIDTH:0]     r_cos;
    logic [BIT_WIDTH:0]     r_sin;

    logic [BIT_WIDTH:0]     w_c;
    logic [BIT_WIDTH:0]     w_s;
    logic [BIT_WIDTH:0]     w_neg_c;
    logic [BIT_WIDTH:0]     w_neg_s;
    logic [BIT_WIDTH:0]     w_cos;
    logic [BIT_WIDTH:0]     w_sin;

    assign w_c     = {1'b0, i_core_out_x};
    assign w_s     = {1'b0, i_core_out_y};
    assign w_neg_c = -w_c;
    assign w_neg_s = -w_s;

    // Rotate the first-quadrant result by q quarter turns.
    always_comb begin
        w_cos = w_c;
        w_sin = w_s;
        unique case (r_quad)
            2'd0: begin w_cos = w_c;     w_sin = w_s;     end
            2'd1: begin w_cos = w_neg_s; w_sin = w_c;     end
            2'd2: begin w_cos = w_neg_c; w_sin = w_neg_s; end
            2'd3: begin w_cos = w_s;     w_sin = w_neg_c; end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_quad  <= '0;
            r_angle <= '0;
            r_cos   <= '0;
            r_sin   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_quad  <= i_req_angle[BIT_WIDTH+1:BIT_WIDTH];
                        r_angle <= i_req_angle[BIT_WIDTH-1:0];
                        r_state <= StLaunch;
                    end
                end
                // A stale core_done here belongs to a previous run and is ignored.
                StLaunch: begin
                    if (!i_core_ready) r_state <= StBusy;
                end
                StBusy: begin
                    if (i_core_done) begin
                        r_cos   <= w_cos;
                        r_sin   <= w_sin;
                        r_state <= StHold;
                    end
                end
                StHold: begin
                    if (i_res_ready) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_req_ready  = (r_state == StIdle);
    assign o_res_valid  = (r_state == StHold);
    assign o_core_start = (r_state == StLaunch);
    assign o_core_mode  = 1'b0;
    assign o_core_angle = r_angle;
    assign o_core_x     = K;
    assign o_core_y     = '0;
    assign o_res_cos    = r_cos;
    assign o_res_sin    = r_sin;

endmodule

// File: tb/tb_cordic_quadrant_ctrl.sv
// Bench for cordic_quadrant_ctrl: trig-based core stub plus a quarter-turn rotation model.
module tb_cordic_quadrant_ctrl;

    localparam int unsigned BW = 16;
    localparam logic [BW-1:0] KC = 16'd39797;
    localparam real PI = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [BW+1:0]        req_angle = '0;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic signed [BW:0]   res_cos;
    logic signed [BW:0]   res_sin;
    logic                 core_start;
    logic                 core_mode;
    logic [BW-1:0]        core_angle;
    logic [BW-1:0]        core_x;
    logic [BW-1:0]        core_y;
    logic                 core_ready;
    logic                 core_done;
    logic [BW-1:0]        core_out_x;
    logic [BW-1:0]        core_out_y;

    int errors = 0;
    int checks = 0;
    int starts = 0;
    int accepts = 0;
    int results = 0;
    int force_lat = 0;
    int rr_mode = 1;
    logic rr_manual = 1'b0;
    logic prev_start = 1'b0;
    int exp_cos_q[$];
    int exp_sin_q[$];

    cordic_quadrant_ctrl #(.BIT_WIDTH(BW), .K(KC)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_angle  (req_angle),
        .o_res_valid  (res_valid),
        .i_res_ready  (res_ready),
        .o_res_cos    (res_cos),
        .o_res_sin    (res_sin),
        .o_core_start (core_start),
        .o_core_mode  (core_mode),
        .o_core_angle (core_angle),
        .o_core_x     (core_x),
        .o_core_y     (core_y),
        .i_core_ready (core_ready),
        .i_core_done  (core_done),
        .i_core_out_x (core_out_x),
        .i_core_out_y (core_out_y)
    );

    always #5 clk = ~clk;

    function automatic int rnd(real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic int cos_u(int phi);
        return rnd(65535.0 * $cos(phi * PI / 131072.0));
    endfunction

    function automatic int sin_u(int phi);
        return rnd(65535.0 * $sin(phi * PI / 131072.0));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int exp);
        checks++;
        if (act > exp + 2 || act < exp - 2) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +-2", name, act, exp);
        end
    endtask

    // Core stub: sticky done, variable accept delay and compute latency.
    int acc_wait = 0;
    int cnt = 0;
    logic [BW-1:0] st_ang = '0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_ready <= 1'b1;
            core_done  <= 1'b0;
            core_out_x <= '0;
            core_out_y <= '0;
            acc_wait   <= 0;
            cnt        <= 0;
        end else if (core_ready) begin
            if (core_start) begin
                if (acc_wait > 0) acc_wait <= acc_wait - 1;
                else begin
                    core_ready <= 1'b0;
                    core_done  <= 1'b0;
                    st_ang     <= core_angle;
                    cnt        <= (force_lat != 0) ? force_lat : $urandom_range(1, 8);
                end
            end
        end else if (cnt > 1) begin
            cnt <= cnt - 1;
        end else begin
            core_ready <= 1'b1;
            core_done  <= 1'b1;
            core_out_x <= BW'(cos_u(int'(st_ang)));
            core_out_y <= BW'(sin_u(int'(st_ang)));
            acc_wait   <= $urandom_range(0, 2);
        end
    end

    always @(posedge clk) begin
        #2;
        if (rr_mode == 0) res_ready = ($urandom_range(0, 2) != 0);
        else if (rr_mode == 1) res_ready = 1'b1;
        else res_ready = rr_manual;
    end

    // Monitor: checks held results against the model, records accepts and launches.
    always @(negedge clk) begin
        if (!reset) begin
            int c, s, x, y, t, q;
            chk("core_mode", int'(core_mode), 0);
            chk("core_x", int'(core_x), int'(KC));
            chk("core_y", int'(core_y), 0);
            if (core_start && !prev_start) starts++;
            prev_start = core_start;
            if (res_valid) begin
                chk("req_ready_in_hold", int'(req_ready), 0);
                if (exp_cos_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("res_cos", int'(res_cos), exp_cos_q[0]);
                    chk("res_sin", int'(res_sin), exp_sin_q[0]);
                    if (res_ready) begin
                        void'(exp_cos_q.pop_front());
                        void'(exp_sin_q.pop_front());
                        results++;
                    end
                end
            end
            if (req_valid && req_ready) begin
                q = int'(req_angle[BW+1:BW]);
                c = cos_u(int'(req_angle[BW-1:0]));
                s = sin_u(int'(req_angle[BW-1:0]));
                x = c;
                y = s;
                for (int i = 0; i < q; i++) begin
                    t = x;
                    x = -y;
                    y = t;
                end
                exp_cos_q.push_back(x);
                exp_sin_q.push_back(y);
                accepts++;
            end
        end else begin
            prev_start = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input int q, input int phi);
        int n;
        req_valid = 1'b1;
        req_angle = {2'(q), BW'(phi)};
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 2000) begin
                $display("FAIL accept_timeout: got no accept expected accept within 2000 cycles");
                $fatal(1, "accept timeout");
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (res_valid) break;
            n++;
            if (n > 500) begin
                chk("result_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic lit(input int q, input int phi, input int ec, input int es);
        send(q, phi);
        req_valid = 1'b0;
        wait_result();
        chk_tol("lit_cos", int'(res_cos), ec);
        chk_tol("lit_sin", int'(res_sin), es);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_cos_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", exp_cos_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b2b_start;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_core_start", int'(core_start), 0);
        chk("rst_res_cos", int'(res_cos), 0);
        chk("rst_res_sin", int'(res_sin), 0);
        chk("rst_core_angle", int'(core_angle), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        rr_mode = 1;
        lit(0, 0, 65535, 0);
        lit(1, 0, 0, 65535);
        lit(2, 32768, -46341, -46341);
        lit(3, 32768, 46341, -46341);

        // Async reset in the middle of a long core run.
        force_lat = 30;
        send(2, 12345);
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_req_ready", int'(req_ready), 1);
        chk("mid_rst_res_valid", int'(res_valid), 0);
        chk("mid_rst_core_start", int'(core_start), 0);
        chk("mid_rst_res_cos", int'(res_cos), 0);
        chk("mid_rst_res_sin", int'(res_sin), 0);
        chk("mid_rst_core_angle", int'(core_angle), 0);
        exp_cos_q.delete();
        exp_sin_q.delete();
        @(posedge clk);
        #3;
        reset = 1'b0;
        force_lat = 0;
        @(posedge clk);
        #1;
        lit(0, 0, 65535, 0);

        // Hold for 20 cycles with a pending request.
        rr_manual = 1'b0;
        rr_mode = 2;
        send(1, 1000);
        req_valid = 1'b1;
        req_angle = {2'd2, 16'd5000};
        wait_result();
        repeat (20) begin
            @(negedge clk);
            chk("hold_res_valid", int'(res_valid), 1);
            chk("hold_req_ready", int'(req_ready), 0);
            chk("hold_core_start", int'(core_start), 0);
        end
        @(posedge clk);
        #1;
        rr_manual = 1'b1;
        @(posedge clk);
        #1;
        rr_manual = 1'b0;
        chk("release_req_ready", int'(req_ready), 1);
        chk("release_res_valid", int'(res_valid), 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("pending_taken", int'(req_ready), 0);
        chk("pending_launch", int'(core_start), 1);
        rr_mode = 1;
        drain();

        // Randomized traffic with random consumer back-pressure.
        rr_mode = 0;
        for (int i = 0; i < 60; i++) begin
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
            if ($urandom_range(0, 1) == 1) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        rr_mode = 1;
        drain();

        // Back-to-back with req_valid held high.
        b2b_start = starts;
        for (int i = 0; i < 12; i++)
            send(i % 4, int'($urandom_range(0, 65535)));
        req_valid = 1'b0;
        drain();
        chk("b2b_launch_bursts", starts - b2b_start, 12);
        chk("total_launches", starts, accepts);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
